wall_gen: RTL
=============

WALL_GEN -- requirements
Module: wall_gen

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels; spawn column is SCREEN_W-1.
REQ-002 SHALL have parameter TICK_DIV, default 250000, clk cycles per scroll tick.
REQ-003 SHALL have parameter MIN_BOTTOM, default 8, offset added to rand_in.
REQ-004 SHALL have parameter GAP_H, default 24, vertical gap height.
REQ-005 SHALL have parameter WALL_W, default 8, wall width; parameter BIRD_X, default 40, player column.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port start, input, 1, level; game running.
REQ-009 SHALL have port halt, input, 1, level; collision freeze.
REQ-010 SHALL have port rand_in, input, 6, from the upstream LFSR.
REQ-011 SHALL have outputs: wall_x (8 bits), gap_bottom (7), gap_top (7), wall_active (1), spawn_pulse (1), pass_pulse (1), walls_passed (8).

Function
REQ-012 SHALL have states IDLE, SPAWN, SCROLL, FROZEN.
REQ-013 In IDLE with start=1, SHALL go to SPAWN next cycle; otherwise SHALL stay in IDLE.
REQ-014 SPAWN SHALL last exactly one cycle and SHALL do all of: latch gap_bottom=rand_in+MIN_BOTTOM; set gap_top=gap_bottom+GAP_H; set wall_x=SCREEN_W-1; clear tick counter; assert spawn_pulse; go to SCROLL.
REQ-015 gap_bottom and gap_top SHALL be 7-bit unsigned with no wrap; defaults give ranges 8..71 and 32..95.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 only in SCROLL; tick SHALL be when count==TICK_DIV-1, after which the counter returns to 0.
REQ-017 The first tick after SPAWN SHALL occur TICK_DIV cycles after SCROLL is entered.
REQ-018 On tick in SCROLL: if wall_x >= step, SHALL set wall_x-=step; else SHALL go to SPAWN (wall_x not decremented).
REQ-019 pass_pulse SHALL be high for one cycle when a tick moves wall_x from (old wall_x+WALL_W > BIRD_X) to (new wall_x+WALL_W <= BIRD_X).
REQ-020 On each pass_pulse, walls_passed SHALL increment; at 255 it SHALL saturate.
REQ-021 wall_active SHALL be 1 in SPAWN, SCROLL and FROZEN, and 0 in IDLE.
REQ-022 halt=1 in SPAWN or SCROLL SHALL cause FROZEN next cycle. In FROZEN, wall_x, gaps and the counter SHALL hold, and no pulses SHALL occur.
REQ-023 start=0 in any non-IDLE state SHALL cause IDLE next cycle, with wall_x=SCREEN_W-1 and walls_passed=0. This SHALL take priority over halt and tick.
REQ-024 If halt and tick coincide, halt SHALL win: no decrement and no pass_pulse.
REQ-025 FROZEN SHALL exit only through start=0, going to IDLE.

Reset
REQ-026 When reset=1 at a posedge: state=IDLE, wall_x=SCREEN_W-1, gap_bottom=0, gap_top=0, tick counter=0, walls_passed=0, wall_active=0, spawn_pulse=0, pass_pulse=0.
REQ-027 Reset SHALL override all other inputs, including mid-SCROLL and in FROZEN.

Configuration
REQ-028 Macro WALL_SPEEDUP_EN defined: step = 1 + min(walls_passed>>3, 3), range 1..4.
REQ-029 WALL_SPEEDUP_EN undefined: step SHALL be constant 1, with no speed logic synthesized.

Verification
REQ-030 Bench SHALL use params TICK_DIV=4, SCREEN_W=160, BIRD_X=40, WALL_W=8, MIN_BOTTOM=8, GAP_H=24.
REQ-031 Scenario: reset, then start=1 and rand_in=6'd20 -> spawn_pulse on cycle 2, gap_bottom=28, gap_top=52, wall_x=159; wall_x=158 four cycles after SCROLL entry.
REQ-032 Scenario: rand_in=6'd63 at SPAWN -> gap_bottom=71, gap_top=95 (no wrap).
REQ-033 Scenario: scroll without speedup -> single pass_pulse on the tick where wall_x goes 33->32; walls_passed=1; at wall_x=0 the next tick -> SPAWN, new spawn_pulse.
REQ-034 Scenario: halt=1 at wall_x=100 coincident with a tick -> wall_x stays 100 through FROZEN; then start=0 -> IDLE, wall_x=159, walls_passed=0.
REQ-035 Scenario: reset asserted mid-SCROLL at wall_x=70 -> next cycle all outputs at reset values; with WALL_SPEEDUP_EN and walls_passed=8 -> step=2 per tick.

Source files
------------

// File: rtl/wall_gen.sv
// Scrolling wall generator: spawns a wall with a random gap, scrolls it left each tick,
// and counts walls the bird has cleared. Define WALL_SPEEDUP_EN to raise scroll speed as walls are passed.
module wall_gen #(
  parameter int SCREEN_W   = 160,
  parameter int TICK_DIV   = 250000,
  parameter int MIN_BOTTOM = 8,
  parameter int GAP_H      = 24,
  parameter int WALL_W     = 8,
  parameter int BIRD_X     = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt,
  input  logic [5:0] rand_in,
  output logic [7:0] wall_x,
  output logic [6:0] gap_bottom,
  output logic [6:0] gap_top,
  output logic       wall_active,
  output logic       spawn_pulse,
  output logic       pass_pulse,
  output logic [7:0] walls_passed
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);

  typedef enum logic [1:0] {IDLE, SPAWN, SCROLL, FROZEN} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_wallX;
  logic [6:0]       r_gapBottom;
  logic [6:0]       r_gapTop;
  logic [CNT_W-1:0] r_tickCnt;
  logic [7:0]       r_wallsPassed;
  logic             r_wallActive;
  logic             r_spawnPulse;
  logic             r_passPulse;

  logic       w_tick;
  logic       w_move;
  logic       w_pass;
  logic [7:0] w_step;
  logic [7:0] w_newX;
  logic [6:0] w_gapBottom;
  logic [6:0] w_gapTop;

`ifdef WALL_SPEEDUP_EN
  // One extra pixel per tick for every eight walls passed, capped at four.
  assign w_step = (r_wallsPassed[7:3] >= 5'd3) ? 8'd4 : ({3'b000, r_wallsPassed[7:3]} + 8'd1);
`else
  assign w_step = 8'd1;
`endif

  assign w_tick      = (r_state == SCROLL) && (r_tickCnt == TICK_LAST);
  assign w_newX      = r_wallX - w_step;
  assign w_gapBottom = {1'b0, rand_in} + 7'(MIN_BOTTOM);
  assign w_gapTop    = w_gapBottom + 7'(GAP_H);

  always_comb begin
    w_nextState = r_state;
    w_move      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = SPAWN;
      end
      SPAWN: begin
        if (!start)    w_nextState = IDLE;
        else if (halt) w_nextState = FROZEN;
        else           w_nextState = SCROLL;
      end
      SCROLL: begin
        if (!start)     w_nextState = IDLE;
        else if (halt)  w_nextState = FROZEN;
        else if (w_tick) begin
          if (r_wallX >= w_step) w_move = 1'b1;
          else                   w_nextState = SPAWN;
        end
      end
      FROZEN: begin
        if (!start) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The bird is cleared on the tick where the wall's trailing edge crosses to its left.
  assign w_pass = w_move
                  && (({1'b0, r_wallX} + 9'(WALL_W)) > 9'(BIRD_X))
                  && (({1'b0, w_newX} + 9'(WALL_W)) <= 9'(BIRD_X));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wallX       <= SPAWN_X;
      r_gapBottom   <= '0;
      r_gapTop      <= '0;
      r_tickCnt     <= '0;
      r_wallsPassed <= '0;
      r_wallActive  <= 1'b0;
      r_spawnPulse  <= 1'b0;
      r_passPulse   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_wallActive <= (w_nextState != IDLE);
      r_spawnPulse <= (w_nextState == SPAWN);
      r_passPulse  <= w_pass;
      if (w_nextState == IDLE) begin
        r_wallX       <= SPAWN_X;
        r_wallsPassed <= '0;
        r_tickCnt     <= '0;
      end else if (w_nextState == SPAWN) begin
        r_gapBottom <= w_gapBottom;
        r_gapTop    <= w_gapTop;
        r_wallX     <= SPAWN_X;
        r_tickCnt   <= '0;
      end else if ((r_state == SCROLL) && (w_nextState == SCROLL)) begin
        r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
        if (w_move) r_wallX <= w_newX;
        if (w_pass && (r_wallsPassed != 8'hFF)) r_wallsPassed <= r_wallsPassed + 8'd1;
      end
    end
  end

  assign wall_x       = r_wallX;
  assign gap_bottom   = r_gapBottom;
  assign gap_top      = r_gapTop;
  assign wall_active  = r_wallActive;
  assign spawn_pulse  = r_spawnPulse;
  assign pass_pulse   = r_passPulse;
  assign walls_passed = r_wallsPassed;

endmodule
